control_fsm: RTL
================

Name: control_fsm

Overview:
- Multi-cycle control unit that sequences the miniRISC `data_path`.
- Loads each instruction, latches `opcode_out`/`func_out` from the datapath, then drives all datapath control lines through execute, memory and writeback phases.
- Asserts PC advance once per instruction and counts retired instructions.
- Sits beside `data_path` in the CPU top level; replaces hand-driven control stimulus.

Parameters:
- CNT_W, 16, width of retired-instruction counter (saturating)

Ports:
- clk  input  1  system clock, all state updates on rising edge
- rst  input  1  synchronous active-high reset
- start  input  1  leave IDLE and begin fetching
- stall  input  1  freeze FSM, latched fields, counter and all outputs while high
- opcode_in  input  6  from `data_path.opcode_out`
- func_in  input  6  from `data_path.func_out`
- ir_load  output  1  load instruction register
- pc_en  output  1  advance/update PC this cycle
- reg_write  output  2  register-file write enable/port select
- imm_mux_ctrl  output  1  immediate source select
- alu_mux_ctrl  output  1  ALU B operand: 0 = register, 1 = immediate
- alu_op  output  4  ALU operation
- dmem_enable  output  1  data memory enable
- dmem_write_enable  output  1  data memory write
- reg_write_mux_ctrl  output  2  writeback source: 00 = PC link, 01 = memory, 10 = ALU
- br_op  output  5  one-hot branch type, 0 = none
- halted  output  1  HALT reached
- illegal  output  1  one-cycle pulse on unknown opcode
- instr_count  output  CNT_W  retired instructions

Behaviour:
- Reset (synchronous, `rst`=1 at edge):
  - state = IDLE.
  - All outputs 0, including `instr_count`.
  - Latched opcode/func cleared.
  - Reset overrides `stall` and any state, including mid-instruction.
- States: IDLE, FETCH, DECODE, EXEC, MEM, WB, HALT.
- IDLE:
  - All outputs 0.
  - `start`=1 -> FETCH.
- FETCH:
  - `ir_load`=1 for this cycle only.
  - -> DECODE.
- DECODE:
  - Capture `opcode_in`/`func_in` into internal registers; later states use only the latched values.
  - Dispatch:
    - opcodes 0–4 -> EXEC.
    - 5–9 -> EXEC.
    - 6'h3F -> HALT.
    - any other -> FETCH with `illegal`=1 and `pc_en`=1 for one cycle; the instruction is skipped, not counted.
- Opcode map:
  - 0 = R-type: `alu_op`=`func[3:0]`, `alu_mux`=0.
  - 1 = addi: `alu_op`=0, `alu_mux`=1.
  - 2 = compi: `alu_op`=1, `alu_mux`=1.
  - 3 = lw: `alu_op`=0, `imm_mux`=1, `alu_mux`=1.
  - 4 = sw: `alu_op`=0, `imm_mux`=1, `alu_mux`=1.
  - 5..9 = branch: `br_op` = 5'b00001 << (opcode−5); opcode 9 is branch-and-link.
- Datapath controls hold stable from EXEC through the last state of the instruction; they return to 0 in FETCH.
- EXEC:
  - R/I (opcodes 0–2) -> WB.
  - lw/sw -> MEM.
  - Branch: `br_op` driven, `pc_en`=1.
    - Opcode 9 additionally `reg_write`=01, `reg_write_mux_ctrl`=00 in this same cycle.
    - Retire; -> FETCH.
- MEM:
  - `dmem_enable`=1.
  - sw: `dmem_write_enable`=1, `pc_en`=1, retire, -> FETCH.
  - lw: `dmem_write_enable`=0, -> WB.
- WB:
  - R/I: `reg_write`=01, `reg_write_mux_ctrl`=10.
  - lw: `reg_write`=10, `reg_write_mux_ctrl`=01, `dmem_enable` held 1.
  - `pc_en`=1, retire, -> FETCH.
- `reg_write` is nonzero only in WB, or in EXEC for opcode 9.
- Cycle counts per instruction (FETCH to next FETCH, no stalls):
  - Branch 3.
  - R/I 4.
  - sw 4.
  - lw 5.
  - Illegal 2.
- HALT:
  - `halted`=1; all other controls 0.
  - Remain in HALT until `rst`; `start` is ignored.
- Stall:
  - No state transition, no latch, no count while `stall`=1; outputs keep their previous-cycle values.
  - A retire occurring in a stalled cycle counts exactly once, when `stall` drops.
- `instr_count`:
  - +1 on each retire.
  - Saturates at all-ones with no wrap.
- `start` while not in IDLE: ignored.

Test Plan:
- Reset then `start` pulse; opcode 0, func 3 (xor) -> `ir_load` high exactly 1 cycle; WB on cycle 4 with `reg_write`=01, `alu_op`=3, `reg_write_mux_ctrl`=10; `instr_count`=1.
- addi (opcode 1) then sw (opcode 4) -> addi: `alu_mux`=1, `alu_op`=0. sw MEM cycle: `dmem_enable`=1, `dmem_write_enable`=1, `reg_write`=0, `pc_en`=1. `instr_count`=2 after 8 cycles.
- lw (opcode 3) -> MEM `dmem_enable`=1, write 0; WB `reg_write`=10, mux=01; next FETCH 5 cycles after first.
- Branches opcodes 5–9 -> `br_op` = 00001, 00010, 00100, 01000, 10000 in EXEC with `pc_en`=1. Opcode 9 also `reg_write`=01, mux=00; all others `reg_write`=0.
- Opcode 6'h12 -> `illegal` 1-cycle pulse, `instr_count` unchanged. Opcode 6'h3F -> `halted`=1 held for 20 cycles despite `start` toggles.
- Stall and reset:
  - `stall`=1 for 3 cycles during lw MEM -> outputs frozen; lw still totals 5 active cycles.
  - `rst` mid-WB -> next cycle IDLE, all outputs 0.
  - With CNT_W=2, five retires -> `instr_count`=3.

Source files
------------

// File: rtl/control_fsm.sv
// ============================================================================
// control_fsm : multi-cycle miniRISC control unit that sequences data_path
// Revision    : 1.0
// ============================================================================
`default_nettype none

module control_fsm #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             stall,
  input  logic [5:0]       opcode_in,
  input  logic [5:0]       func_in,
  output logic             ir_load,
  output logic             pc_en,
  output logic [1:0]       reg_write,
  output logic             imm_mux_ctrl,
  output logic             alu_mux_ctrl,
  output logic [3:0]       alu_op,
  output logic             dmem_enable,
  output logic             dmem_write_enable,
  output logic [1:0]       reg_write_mux_ctrl,
  output logic [4:0]       br_op,
  output logic             halted,
  output logic             illegal,
  output logic [CNT_W-1:0] instr_count
);

  localparam logic [5:0] OP_RTYPE = 6'd0;
  localparam logic [5:0] OP_LW    = 6'd3;
  localparam logic [5:0] OP_SW    = 6'd4;
  localparam logic [5:0] OP_BR0   = 6'd5;
  localparam logic [5:0] OP_BAL   = 6'd9;
  localparam logic [5:0] OP_HALT  = 6'h3F;

  localparam logic [1:0] WSEL_LINK = 2'b00;
  localparam logic [1:0] WSEL_MEM  = 2'b01;
  localparam logic [1:0] WSEL_ALU  = 2'b10;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_HALT   = 3'd6
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [5:0]       op_q;
  logic [5:0]       func_q;
  logic [CNT_W-1:0] count_q;
  logic             retire;

  // Instruction class of the latched opcode
  logic       is_lw;
  logic       is_sw;
  logic       is_br;
  logic       is_bal;
  logic       dec_valid;
  logic       dec_halt;

  // Datapath controls that stay stable from EXEC to the end of the instruction
  logic [3:0] ex_alu_op;
  logic       ex_alu_mux;
  logic       ex_imm_mux;
  logic [4:0] ex_br_op;

  assign is_lw  = (op_q == OP_LW);
  assign is_sw  = (op_q == OP_SW);
  assign is_br  = (op_q >= OP_BR0) && (op_q <= OP_BAL);
  assign is_bal = (op_q == OP_BAL);

  assign dec_valid = (opcode_in <= OP_BAL);
  assign dec_halt  = (opcode_in == OP_HALT);

  assign instr_count = count_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      op_q    <= 6'd0;
      func_q  <= 6'd0;
      count_q <= '0;
    end else if (!stall) begin
      state <= state_nxt;
      if (state == S_DECODE) begin
        op_q   <= opcode_in;
        func_q <= func_in;
      end
      if (retire && (count_q != {CNT_W{1'b1}})) begin
        count_q <= count_q + 1'b1;
      end
    end
  end

  always_comb begin
    ex_alu_op  = 4'd0;
    ex_alu_mux = 1'b0;
    ex_imm_mux = 1'b0;
    ex_br_op   = 5'd0;
    if (op_q == OP_RTYPE) begin
      ex_alu_op = func_q[3:0];
    end else if (op_q == 6'd1) begin
      ex_alu_mux = 1'b1;
    end else if (op_q == 6'd2) begin
      ex_alu_op  = 4'd1;
      ex_alu_mux = 1'b1;
    end else if (is_lw || is_sw) begin
      ex_imm_mux = 1'b1;
      ex_alu_mux = 1'b1;
    end else if (is_br) begin
      ex_br_op = 5'b00001 << (op_q - OP_BR0);
    end
  end

  always_comb begin
    state_nxt          = state;
    retire             = 1'b0;
    ir_load            = 1'b0;
    pc_en              = 1'b0;
    reg_write          = 2'b00;
    imm_mux_ctrl       = 1'b0;
    alu_mux_ctrl       = 1'b0;
    alu_op             = 4'd0;
    dmem_enable        = 1'b0;
    dmem_write_enable  = 1'b0;
    reg_write_mux_ctrl = 2'b00;
    br_op              = 5'd0;
    halted             = 1'b0;
    illegal            = 1'b0;

    if ((state == S_EXEC) || (state == S_MEM) || (state == S_WB)) begin
      alu_op       = ex_alu_op;
      alu_mux_ctrl = ex_alu_mux;
      imm_mux_ctrl = ex_imm_mux;
      br_op        = ex_br_op;
    end

    case (state)
      S_IDLE: begin
        if (start) state_nxt = S_FETCH;
      end
      S_FETCH: begin
        ir_load   = 1'b1;
        state_nxt = S_DECODE;
      end
      S_DECODE: begin
        // Dispatch looks at the live opcode; the latch closes on this same edge
        if (dec_valid) begin
          state_nxt = S_EXEC;
        end else if (dec_halt) begin
          state_nxt = S_HALT;
        end else begin
          illegal   = 1'b1;
          pc_en     = 1'b1;
          state_nxt = S_FETCH;
        end
      end
      S_EXEC: begin
        if (is_br) begin
          pc_en = 1'b1;
          if (is_bal) begin
            reg_write          = 2'b01;
            reg_write_mux_ctrl = WSEL_LINK;
          end
          retire    = 1'b1;
          state_nxt = S_FETCH;
        end else if (is_lw || is_sw) begin
          state_nxt = S_MEM;
        end else begin
          state_nxt = S_WB;
        end
      end
      S_MEM: begin
        dmem_enable = 1'b1;
        if (is_sw) begin
          dmem_write_enable = 1'b1;
          pc_en             = 1'b1;
          retire            = 1'b1;
          state_nxt         = S_FETCH;
        end else begin
          state_nxt = S_WB;
        end
      end
      S_WB: begin
        if (is_lw) begin
          reg_write          = 2'b10;
          reg_write_mux_ctrl = WSEL_MEM;
          dmem_enable        = 1'b1;
        end else begin
          reg_write          = 2'b01;
          reg_write_mux_ctrl = WSEL_ALU;
        end
        pc_en     = 1'b1;
        retire    = 1'b1;
        state_nxt = S_FETCH;
      end
      S_HALT: begin
        halted = 1'b1;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

endmodule

`default_nettype wire
